// File: rtl/pronoc_pkg.sv
// Shared NoC types and constants for the packet-injection path.
// The request queue takes its default minimum packet size from PCK_INJ_MIN_SIZE.
package pronoc_pkg;

  localparam int V         = 4;
  localparam int EAw       = 8;
  localparam int Cw        = 2;
  localparam int WEIGHTw   = 4;
  localparam int PCK_SIZw  = 8;
  localparam int DATAw     = 32;
  localparam int Fpay      = 32;
  localparam int HDR_DATAw = 16;

  // Smallest packet the injector accepts: header plus the flits carrying leftover data bits.
  localparam int PCK_INJ_MIN_SIZE =
    (DATAw > HDR_DATAw) ? ((DATAw - HDR_DATAw + Fpay - 1) / Fpay) + 1 : 1;

  typedef struct packed {
    logic [DATAw-1:0]    data;
    logic [PCK_SIZw-1:0] size;
    logic [EAw-1:0]      endp_addr;
    logic [Cw-1:0]       class_num;
    logic [WEIGHTw-1:0]  init_weight;
    logic [V-1:0]        vc;
    logic                pck_wr;
    logic [V-1:0]        ready;
  } pck_injct_t;

  function automatic logic is_onehot(input logic [V-1:0] v);
    return (v != '0) && ((v & (v - V'(1))) == '0);
  endfunction

endpackage

// File: rtl/pck_inj_queue_fifo.sv
// Generic register-based FIFO with push/pop/count and asynchronous active-high reset.
// Pushes while full and pops while empty are ignored.
module pck_inj_queue_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at the power-of-two depth; count disambiguates full/empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pck_inj_req_queue.sv
// Request queue feeding the packet injector: buffers, screens malformed heads, gates issue on VC ready.
// Optional statistics counters are built when PCK_INJ_QUEUE_STATS_EN is defined.
module pck_inj_req_queue
  import pronoc_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int MIN_SIZE = PCK_INJ_MIN_SIZE,
  parameter bit DROP_BAD = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  pck_injct_t             req_pck,
  output pck_injct_t             pck_injct_o,
  input  logic [V-1:0]           inj_ready_i,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   err_flag,
  output logic [31:0]            pck_sent_cnt,
  output logic [31:0]            flit_sent_cnt
);

  localparam int W = $bits(pck_injct_t);

  logic [W-1:0] fifo_dout;
  pck_injct_t   head;
  logic         full;
  logic         empty;
  logic         head_ok;
  logic         pck_wr;
  logic         push;
  logic         pop;
  logic         unused_bits;

  assign head        = pck_injct_t'(fifo_dout);
  assign req_ready   = ~full;
  assign push        = req_valid & ~full;
  assign head_ok     = (head.size >= PCK_SIZw'(MIN_SIZE)) && is_onehot(head.vc);
  assign pck_wr      = ~empty & head_ok & (|(head.vc & inj_ready_i));
  assign pop         = pck_wr | (~empty & ~head_ok & DROP_BAD);
  assign unused_bits = ^{req_pck.pck_wr, req_pck.ready, head.pck_wr, head.ready};

  pck_inj_queue_fifo #(
    .WIDTH(W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (req_pck),
    .dout (fifo_dout),
    .count(occupancy),
    .full (full),
    .empty(empty)
  );

  always_comb begin
    pck_injct_o = '0;
    if (!empty) begin
      pck_injct_o.endp_addr   = head.endp_addr;
      pck_injct_o.size        = head.size;
      pck_injct_o.class_num   = head.class_num;
      pck_injct_o.vc          = head.vc;
      pck_injct_o.init_weight = head.init_weight;
      pck_injct_o.data        = head.data;
    end
    pck_injct_o.pck_wr = pck_wr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 err_flag <= 1'b0;
    else if (!empty && !head_ok) err_flag <= 1'b1;
  end

`ifdef PCK_INJ_QUEUE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pck_sent_cnt  <= '0;
      flit_sent_cnt <= '0;
    end else if (pck_wr) begin
      pck_sent_cnt  <= pck_sent_cnt + 32'd1;
      flit_sent_cnt <= flit_sent_cnt + 32'(head.size);
    end
  end
`else
  assign pck_sent_cnt  = '0;
  assign flit_sent_cnt = '0;
`endif

endmodule

// File: tb/tb_pck_inj_req_queue.sv
// Directed bench for pck_inj_req_queue: one instance drops malformed heads, one stalls on them.
// Expected statistics depend on whether PCK_INJ_QUEUE_STATS_EN is defined.
module tb_pck_inj_req_queue;
  import pronoc_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_valid_b;
  logic         req_ready, req_ready_b;
  pck_injct_t   req_pck, req_pck_b;
  pck_injct_t   pck_out, pck_out_b;
  logic [V-1:0] inj_ready, inj_ready_b;
  logic [3:0]   occupancy, occupancy_b;
  logic         err_flag, err_flag_b;
  logic [31:0]  pck_cnt, pck_cnt_b, flit_cnt, flit_cnt_b;

  int checks = 0;
  int errors = 0;
  int ready_changes = 0;
  time last_change = 0;

  always #5 clk = ~clk;

  pck_inj_req_queue #(.DEPTH(8), .DROP_BAD(1'b1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_pck(req_pck), .pck_injct_o(pck_out), .inj_ready_i(inj_ready),
    .occupancy(occupancy), .err_flag(err_flag),
    .pck_sent_cnt(pck_cnt), .flit_sent_cnt(flit_cnt)
  );

  pck_inj_req_queue #(.DEPTH(8), .DROP_BAD(1'b0)) dut_stall (
    .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_pck(req_pck_b), .pck_injct_o(pck_out_b), .inj_ready_i(inj_ready_b),
    .occupancy(occupancy_b), .err_flag(err_flag_b),
    .pck_sent_cnt(pck_cnt_b), .flit_sent_cnt(flit_cnt_b)
  );

  // Ready toggling repeatedly inside one timestep while a write is up means a combinational loop.
  always @(inj_ready or inj_ready_b) begin
    if ($time == last_change) ready_changes++;
    else ready_changes = 1;
    last_change = $time;
    if (ready_changes > 2 && (pck_out.pck_wr || pck_out_b.pck_wr)) begin
      $display("[TB] FAIL comb_loop: inj_ready changed %0d times at %0t with pck_wr high", ready_changes, $time);
      $fatal(1, "[TB] combinational loop on inj_ready");
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time %0t reached, required completion earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input pck_injct_t pck, input logic [V-1:0] rdy);
    @(negedge clk);
    req_valid = valid;
    req_pck   = pck;
    inj_ready = rdy;
    #1;
  endtask

  function automatic pck_injct_t make_req(input int addr, input int size, input logic [V-1:0] vc);
    pck_injct_t p;
    p             = '0;
    p.endp_addr   = EAw'(addr);
    p.size        = PCK_SIZw'(size);
    p.vc          = vc;
    p.class_num   = 2'd1;
    p.init_weight = 4'd1;
    p.data        = 32'hA5000000 | 32'(addr);
    return p;
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int exp_pck;
    int exp_flit;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_pck     = '0;
    inj_ready   = '0;
    req_valid_b = 1'b0;
    req_pck_b   = '0;
    inj_ready_b = '0;

    @(negedge clk);
    #1;
    checkOutput("reset_occ", 64'(occupancy), 0);
    checkOutput("reset_req_ready", 64'(req_ready), 1);
    checkOutput("reset_bus", 64'(pck_out), 0);
    checkOutput("reset_err", 64'(err_flag), 0);
    checkOutput("reset_pck_cnt", 64'(pck_cnt), 0);
    checkOutput("reset_flit_cnt", 64'(flit_cnt), 0);
    @(negedge clk);
    reset = 1'b0;

    // Single push, issued one cycle later.
    applyStimulus(1'b1, make_req(1, 4, 4'b0010), 4'b0000);
    checkOutput("t1_no_bypass", 64'(pck_out.pck_wr), 0);
    applyStimulus(1'b0, '0, 4'b0010);
    checkOutput("t1_wr", 64'(pck_out.pck_wr), 1);
    checkOutput("t1_occ1", 64'(occupancy), 1);
    checkOutput("t1_size", 64'(pck_out.size), 4);
    checkOutput("t1_vc", 64'(pck_out.vc), 64'(4'b0010));
    applyStimulus(1'b0, '0, 4'b0010);
    checkOutput("t1_occ0", 64'(occupancy), 0);
    checkOutput("t1_wr_done", 64'(pck_out.pck_wr), 0);
    checkOutput("t1_bus_zero", 64'(pck_out), 0);
    pulse_reset();

    // Three queued requests released one per ready pulse, in order.
    applyStimulus(1'b1, make_req(2, 2, 4'b0001), 4'b0000);
    applyStimulus(1'b1, make_req(3, 5, 4'b0100), 4'b0000);
    applyStimulus(1'b1, make_req(4, 3, 4'b1000), 4'b0000);
    for (int rep = 0; rep < 3; rep++) begin
      for (int k = 0; k < 5; k++) begin
        applyStimulus(1'b0, '0, 4'b0000);
        checkOutput("t2_hold", 64'(pck_out.pck_wr), 0);
      end
      applyStimulus(1'b0, '0, 4'b1111);
      checkOutput("t2_issue", 64'(pck_out.pck_wr), 1);
      checkOutput("t2_order", 64'(pck_out.endp_addr), 64'(2 + rep));
      applyStimulus(1'b0, '0, 4'b0000);
      checkOutput("t2_occ", 64'(occupancy), 64'(2 - rep));
      checkOutput("t2_single", 64'(pck_out.pck_wr), 0);
    end
`ifdef PCK_INJ_QUEUE_STATS_EN
    exp_pck  = 3;
    exp_flit = 10;
`else
    exp_pck  = 0;
    exp_flit = 0;
`endif
    checkOutput("stats_pck", 64'(pck_cnt), 64'(exp_pck));
    checkOutput("stats_flit", 64'(flit_cnt), 64'(exp_flit));

    // Fill to depth, reject the overflow pushes even with a concurrent pop.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, make_req(10 + i, 2, 4'b0001), 4'b0000);
    applyStimulus(1'b1, make_req(99, 2, 4'b0001), 4'b0000);
    checkOutput("t3_full_ready", 64'(req_ready), 0);
    checkOutput("t3_full_occ", 64'(occupancy), 8);
    applyStimulus(1'b1, make_req(100, 2, 4'b0001), 4'b0001);
    checkOutput("t3_occ_after_9th", 64'(occupancy), 8);
    checkOutput("t3_pop_wr", 64'(pck_out.pck_wr), 1);
    checkOutput("t3_pop_ready", 64'(req_ready), 0);
    checkOutput("t3_pop_addr", 64'(pck_out.endp_addr), 10);
    for (int i = 1; i < 8; i++) begin
      applyStimulus(1'b0, '0, 4'b0001);
      if (i == 1) checkOutput("t3_ready_back", 64'(req_ready), 1);
      checkOutput("t3_drain_occ", 64'(occupancy), 64'(8 - i));
      checkOutput("t3_drain_addr", 64'(pck_out.endp_addr), 64'(10 + i));
    end
    applyStimulus(1'b0, '0, 4'b0000);
    checkOutput("t3_empty", 64'(occupancy), 0);

    // Undersized head is dropped without a write; error sticks.
    applyStimulus(1'b1, make_req(5, 1, 4'b0001), 4'b0000);
    applyStimulus(1'b1, make_req(6, 3, 4'b0001), 4'b0001);
    checkOutput("t4_bad_no_wr", 64'(pck_out.pck_wr), 0);
    checkOutput("t4_bad_occ", 64'(occupancy), 1);
    checkOutput("t4_err_before", 64'(err_flag), 0);
    applyStimulus(1'b0, '0, 4'b0001);
    checkOutput("t4_err_set", 64'(err_flag), 1);
    checkOutput("t4_good_wr", 64'(pck_out.pck_wr), 1);
    checkOutput("t4_good_addr", 64'(pck_out.endp_addr), 6);
    applyStimulus(1'b0, '0, 4'b0000);
    checkOutput("t4_occ0", 64'(occupancy), 0);
    checkOutput("t4_err_sticky", 64'(err_flag), 1);

    // Non-one-hot head stalls the non-dropping queue until reset.
    @(negedge clk);
    req_valid_b = 1'b1;
    req_pck_b   = make_req(7, 4, 4'b0110);
    inj_ready_b = 4'b1111;
    @(negedge clk);
    req_pck_b   = make_req(8, 2, 4'b0001);
    @(negedge clk);
    req_valid_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      checkOutput("t5_stall_wr", 64'(pck_out_b.pck_wr), 0);
    end
    checkOutput("t5_stall_occ", 64'(occupancy_b), 2);
    checkOutput("t5_stall_err", 64'(err_flag_b), 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("t5_reset_occ", 64'(occupancy_b), 0);
    checkOutput("t5_reset_err", 64'(err_flag_b), 0);
    checkOutput("t5_reset_bus", 64'(pck_out_b), 0);
    @(negedge clk);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
